fwft_width_packer: RTL and testbench

//  Downstream consumer of the FWFT sync FIFO: pops IN_WIDTH words via the FIFO's

---
 rtl/fwft_width_packer.sv | 134 +++++++++++++
 tb/tb_fwft_width_packer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwft_width_packer.sv
// Packs IN_WIDTH words from a show-ahead FIFO into PACK_RATIO-lane beats on a valid/ready
// stream. Partial beats close on flush or idle timeout, with a keep mask and last flag.
module fwft_width_packer #(
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned PACK_RATIO = 4,
    parameter int unsigned OUT_WIDTH  = IN_WIDTH * PACK_RATIO,
    parameter int unsigned LANE_W     = $clog2(PACK_RATIO + 1),
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [IN_WIDTH-1:0]   fifo_rdata,
    output logic                  fifo_ren,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic [PACK_RATIO-1:0] m_keep,
    output logic                  m_last,
    output logic [LANE_W-1:0]     lane_cnt
);
    localparam int unsigned IDLE_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned IDLE_MAX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [LANE_W-1:0] FULL = LANE_W'(PACK_RATIO);

    logic [PACK_RATIO-1:0][IN_WIDTH-1:0] acc_q, acc_d;
    logic [LANE_W-1:0]                   lane_q, lane_d;
    logic [IDLE_W-1:0]                   idle_q, idle_d;
    logic                                flush_pend_q, flush_pend_d;
    logic                                m_valid_q, m_valid_d;
    logic [PACK_RATIO-1:0][IN_WIDTH-1:0] m_data_q, m_data_d;
    logic [PACK_RATIO-1:0]               m_keep_q, m_keep_d;
    logic                                m_last_q, m_last_d;

    logic out_free;
    logic timeout_req;
    logic flush_req;
    logic xfer;
    logic pop;

    // Handshake decode; m_ready reaches pop only through xfer.
    always_comb begin
        out_free    = !m_valid_q || m_ready;
        timeout_req = (TIMEOUT != 0) && (lane_q != '0) && (idle_q == IDLE_W'(IDLE_MAX));
        flush_req   = flush || flush_pend_q || timeout_req;
        xfer        = out_free && (lane_q != '0) && ((lane_q == FULL) || flush_req);
        pop         = rst_n && !fifo_empty && ((lane_q < FULL) || xfer);
    end

    // Next-state for accumulator, idle timer, pending flush and output register.
    always_comb begin
        acc_d        = acc_q;
        lane_d       = lane_q;
        idle_d       = idle_q;
        flush_pend_d = flush_pend_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;

        if (xfer) begin
            m_valid_d = 1'b1;
            m_data_d  = acc_q;
            m_last_d  = flush_req;
            for (int unsigned i = 0; i < PACK_RATIO; i++) begin
                m_keep_d[i] = (LANE_W'(i) < lane_q);
            end
            acc_d = '0;
            if (pop) begin
                acc_d[0] = fifo_rdata;
                lane_d   = LANE_W'(1);
            end else begin
                lane_d = '0;
            end
        end else begin
            if (m_valid_q && m_ready) begin
                m_valid_d = 1'b0;
            end
            if (pop) begin
                for (int unsigned i = 0; i < PACK_RATIO; i++) begin
                    if (LANE_W'(i) == lane_q) begin
                        acc_d[i] = fifo_rdata;
                    end
                end
                lane_d = lane_q + LANE_W'(1);
            end
        end

        // A flush with nothing held and nothing arriving is dropped.
        if (xfer) begin
            flush_pend_d = 1'b0;
        end else if (flush && ((lane_q != '0) || pop)) begin
            flush_pend_d = 1'b1;
        end

        // Idle timer holds at its terminal count so a blocked timeout stays requested.
        if (pop || xfer || (lane_q == '0)) begin
            idle_d = '0;
        end else if (idle_q != IDLE_W'(IDLE_MAX)) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q        <= '0;
            lane_q       <= '0;
            idle_q       <= '0;
            flush_pend_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            lane_q       <= lane_d;
            idle_q       <= idle_d;
            flush_pend_q <= flush_pend_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
        end
    end

    assign fifo_ren = pop;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_keep   = m_keep_q;
    assign m_last   = m_last_q;
    assign lane_cnt = lane_q;

endmodule

// File: tb/tb_fwft_width_packer.sv
// Scoreboard bench for fwft_width_packer: a queue-based FIFO model feeds the packer and
// expected beats are derived from the pushed bytes, flushes and timeouts.
`timescale 1ns/1ps
module tb_fwft_width_packer;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rdata = 8'h00;
    logic        fifo_ren;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic [2:0]  lane_cnt;

    logic        fifo_empty_b = 1'b1;
    logic [7:0]  fifo_rdata_b = 8'h00;
    logic        fifo_ren_b;
    logic        flush_b = 1'b0;
    logic        m_valid_b;
    logic        m_ready_b = 1'b1;
    logic [31:0] m_data_b;
    logic [3:0]  m_keep_b;
    logic        m_last_b;
    logic [2:0]  lane_cnt_b;

    logic [7:0] fifo_q[$];
    beat_t      exp_q[$];
    int checks = 0;
    int errors = 0;
    int beats_seen = 0;

    always #5 clk = ~clk;

    fwft_width_packer #(.IN_WIDTH(8), .PACK_RATIO(4), .TIMEOUT(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_ren(fifo_ren), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .lane_cnt(lane_cnt)
    );

    fwft_width_packer #(.IN_WIDTH(8), .PACK_RATIO(4), .TIMEOUT(0)) u_dut_nt (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty_b), .fifo_rdata(fifo_rdata_b),
        .fifo_ren(fifo_ren_b), .flush(flush_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .m_data(m_data_b), .m_keep(m_keep_b), .m_last(m_last_b), .lane_cnt(lane_cnt_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // FWFT FIFO model: pop decided from fifo_ren seen before the edge, applied after it.
    initial begin
        logic       do_pop;
        logic [7:0] junk;
        forever begin
            @(negedge clk);
            do_pop = fifo_ren;
            @(posedge clk);
            #1;
            if (do_pop && fifo_q.size() != 0) junk = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
            fifo_rdata = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
            #2;
            fifo_empty = (fifo_q.size() == 0);
            fifo_rdata = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
        end
    end

    // Monitor: compares every accepted beat and checks the beat holds while stalled.
    initial begin
        beat_t       e;
        logic        stall_prev;
        logic [37:0] prev;
        stall_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) check("stall_hold", 64'({m_valid, m_last, m_keep, m_data}), 64'(prev));
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data 0x%08h keep 0x%0h last %0d, no beat expected",
                                 m_data, m_keep, m_last);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 64'({m_data, m_keep, m_last}), 64'({e.data, e.keep, e.last}));
                    end
                    beats_seen++;
                end
                stall_prev = m_valid && !m_ready;
                prev = {1'b1, m_last, m_keep, m_data};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen0;
        int          vb_count;
        int          lowrun;
        logic [31:0] word;
        logic [7:0]  b;

        // Reset state
        ticks(3);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_keep", 64'(m_keep), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_lane_cnt", 64'(lane_cnt), 64'd0);
        check("rst_fifo_ren", 64'(fifo_ren), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: back-to-back full beats, pops on 8 consecutive cycles
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        expect_beat(32'h04030201, 4'hF, 1'b0);
        expect_beat(32'h08070605, 4'hF, 1'b0);
        #2;
        for (int i = 0; i < 8; i++) begin
            check("t1_ren_high", 64'(fifo_ren), 64'd1);
            tick();
        end
        check("t1_ren_low", 64'(fifo_ren), 64'd0);
        drain("t1_drain", 20);

        // 2: backpressure holds the accumulator full and stops popping
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) fifo_q.push_back(8'(8'h10 + i));
        expect_beat(32'h13121110, 4'hF, 1'b0);
        expect_beat(32'h17161514, 4'hF, 1'b0);
        expect_beat(32'h1B1A1918, 4'hF, 1'b0);
        ticks(12);
        check("t2_lane_full", 64'(lane_cnt), 64'd4);
        check("t2_ren_blocked", 64'(fifo_ren), 64'd0);
        check("t2_valid_held", 64'(m_valid), 64'd1);
        check("t2_data_held", 64'(m_data), 64'h13121110);
        m_ready = 1'b1;
        drain("t2_drain", 40);
        check("t2_fifo_empty", 64'(fifo_q.size()), 64'd0);

        // 3: explicit flush of a 3-lane partial beat
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        fifo_q.push_back(8'hCC);
        expect_beat(32'h00CCBBAA, 4'h7, 1'b1);
        ticks(4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain("t3_drain", 10);

        // 4: idle timeout closes a 1-lane beat on the 16th edge; disabled timeout never does
        fifo_q.push_back(8'h5A);
        expect_beat(32'h0000005A, 4'h1, 1'b1);
        fifo_empty_b = 1'b0;
        fifo_rdata_b = 8'h5A;
        #1;
        check("t4_nt_ren", 64'(fifo_ren_b), 64'd1);
        #1;
        tick();
        fifo_empty_b = 1'b1;
        fifo_rdata_b = 8'h00;
        vb_count = 0;
        for (int i = 2; i <= 16; i++) begin
            tick();
            if (m_valid_b) vb_count++;
        end
        check("t4_no_early_timeout", 64'(m_valid), 64'd0);
        tick();
        if (m_valid_b) vb_count++;
        check("t4_timeout_valid", 64'(m_valid), 64'd1);
        check("t4_timeout_beat", 64'({m_data, m_keep, m_last}), 64'({32'h0000005A, 4'h1, 1'b1}));
        for (int i = 18; i <= 100; i++) begin
            tick();
            if (m_valid_b) vb_count++;
        end
        check("t4_nt_no_beat", 64'(vb_count), 64'd0);
        check("t4_nt_lane_held", 64'(lane_cnt_b), 64'd1);
        drain("t4_drain", 5);

        // 5: flush with nothing held is dropped; flush with the first pop yields a 1-lane beat
        seen0 = beats_seen;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ticks(20);
        check("t5_empty_flush_dropped", 64'(beats_seen - seen0), 64'd0);
        check("t5_lane_zero", 64'(lane_cnt), 64'd0);
        fifo_q.push_back(8'h77);
        fifo_q.push_back(8'h88);
        expect_beat(32'h00000077, 4'h1, 1'b1);
        expect_beat(32'h00000088, 4'h1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain("t5_drain", 40);

        // 6: reset mid-beat discards held beat and accumulator
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h30 + i));
        ticks(10);
        check("t6_stalled_valid", 64'(m_valid), 64'd1);
        check("t6_stalled_lane", 64'(lane_cnt), 64'd2);
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h40 + i));
        expect_beat(32'h43424140, 4'hF, 1'b0);
        #2;
        check("t6_ren_in_reset", 64'(fifo_ren), 64'd0);
        tick();
        check("t6_rst_valid", 64'(m_valid), 64'd0);
        check("t6_rst_lane", 64'(lane_cnt), 64'd0);
        check("t6_rst_keep", 64'(m_keep), 64'd0);
        check("t6_rst_data", 64'(m_data), 64'd0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        drain("t6_drain", 30);

        // Random traffic: whole beats with random gaps and short backpressure bursts
        lowrun = 0;
        for (int g = 0; g < 40; g++) begin
            word = '0;
            for (int k = 0; k < 4; k++) begin
                for (int w = $urandom_range(0, 3); w > 0; w--) begin
                    if (lowrun >= 2) begin
                        m_ready = 1'b1;
                        lowrun = 0;
                    end else begin
                        m_ready = ($urandom_range(0, 2) != 0);
                        lowrun = m_ready ? 0 : lowrun + 1;
                    end
                    tick();
                end
                b = 8'($urandom_range(0, 255));
                fifo_q.push_back(b);
                word = word | (32'(b) << (8 * k));
            end
            expect_beat(word, 4'hF, 1'b0);
        end
        m_ready = 1'b1;
        drain("rand_drain", 400);
        check("rand_fifo_empty", 64'(fifo_q.size()), 64'd0);

        ticks(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
